// File: rtl/icap_warmboot.sv
// icap_warmboot -- warm-boot reboot sequencer for the ICAPE2 (X32) port.
//
// Once a boot request is accepted it issues one IPROG command frame so the
// FPGA reconfigures from the image at WBSTAR, then parks in DONE until reset.
//
// Build option: WARMBOOT_DELAY_EN
//   defined     -> a BOOT_DELAY-cycle hold-off (DELAY state) runs before the frame
//   not defined -> IDLE goes straight to SETUP; BOOT_DELAY is unused
//
// Ports:
//   clk_48mhz   in   1   sole clock
//   reset       in   1   synchronous, active-high
//   boot        in   1   reboot request, level-sampled in IDLE only
//   icap_csib   out  1   ICAPE2 CSIB (active low)
//   icap_rdwrb  out  1   ICAPE2 RDWRB (0 = write)
//   icap_i      out  32  ICAPE2 I, bit-swapped within each byte
//   busy        out  1   high from request acceptance until reset
//
// state | meaning
// IDLE  | waiting for boot
// DELAY | hold-off down-counter running (only with WARMBOOT_DELAY_EN)
// SETUP | one cycle with RDWRB low ahead of CSIB assertion
// WRITE | nine frame words, one per cycle
// DONE  | CSIB released, RDWRB released a cycle later; terminal

module icap_warmboot #(
  parameter logic [31:0] WBSTAR     = 32'h0040_0000,
  parameter int          BOOT_DELAY = 4_800_000
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic        boot,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_SETUP = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        csib_nxt, rdwrb_nxt, busy_nxt;
  logic [31:0] data_nxt;

  // ICAP expects each byte bit-reversed relative to the bitstream word.
  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++)
        r[8*k+j] = w[8*k+7-j];
    return r;
  endfunction

  function automatic logic [31:0] frame_word(input logic [3:0] n);
    logic [31:0] w;
    case (n)
      4'd0:    w = 32'hFFFF_FFFF;  // dummy
      4'd1:    w = 32'hAA99_5566;  // sync
      4'd2:    w = 32'h2000_0000;  // NOOP
      4'd3:    w = 32'h3002_0001;  // write WBSTAR
      4'd4:    w = WBSTAR;
      4'd5:    w = 32'h2000_0000;  // NOOP
      4'd6:    w = 32'h3000_8001;  // write CMD
      4'd7:    w = 32'h0000_000F;  // IPROG
      4'd8:    w = 32'h2000_0000;  // NOOP
      default: w = 32'hFFFF_FFFF;
    endcase
    return bswap(w);
  endfunction

`ifdef WARMBOOT_DELAY_EN
  localparam int CW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_48mhz) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end
`else
  logic unused_delay;
  assign unused_delay = ^BOOT_DELAY;
`endif

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
`ifdef WARMBOOT_DELAY_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      S_IDLE: begin
        if (boot) begin
`ifdef WARMBOOT_DELAY_EN
          state_nxt = S_DELAY;
          cnt_nxt   = CW'(BOOT_DELAY - 1);
`else
          state_nxt = S_SETUP;
`endif
        end
      end
`ifdef WARMBOOT_DELAY_EN
      S_DELAY: begin
        if (cnt == '0) state_nxt = S_SETUP;
        else           cnt_nxt   = cnt - 1'b1;
      end
`endif
      S_SETUP: begin
        idx_nxt   = '0;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (idx == 4'd8) state_nxt = S_DONE;
        else             idx_nxt   = idx + 4'd1;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state
  // register by one edge; busy alone is taken at the accepting edge.
  always_comb begin
    csib_nxt  = 1'b1;
    rdwrb_nxt = 1'b1;
    data_nxt  = 32'hFFFF_FFFF;
    busy_nxt  = busy | ((state == S_IDLE) & boot);
    case (state)
      S_SETUP: rdwrb_nxt = 1'b0;
      S_WRITE: begin
        csib_nxt  = 1'b0;
        rdwrb_nxt = 1'b0;
        data_nxt  = frame_word(idx);
      end
      // RDWRB follows CSIB with one cycle of lag, so it stays low for the
      // edge on which CSIB deasserts and rises on the next.
      S_DONE:  rdwrb_nxt = icap_csib;
      default: ;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= 32'hFFFF_FFFF;
      busy       <= 1'b0;
    end else begin
      icap_csib  <= csib_nxt;
      icap_rdwrb <= rdwrb_nxt;
      icap_i     <= data_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_icap_warmboot.sv
// Bench for icap_warmboot: directed steps with a scoreboard queue of the
// expected byte-swapped ICAP words. Builds with or without WARMBOOT_DELAY_EN.

module tb_icap_warmboot;

`ifdef WARMBOOT_DELAY_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 0;
`endif

  logic        clk_48mhz;
  logic        reset;
  logic        boot;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_i;
  logic        busy;

  icap_warmboot #(
    .WBSTAR     (32'h0040_0000),
    .BOOT_DELAY (10)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .boot       (boot),
    .icap_csib  (icap_csib),
    .icap_rdwrb (icap_rdwrb),
    .icap_i     (icap_i),
    .busy       (busy)
  );

  initial clk_48mhz = 1'b0;
  always #5 clk_48mhz = ~clk_48mhz;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // Expected ICAP words for the default WBSTAR, already byte bit-swapped.
  logic [31:0] frame_exp [9] = '{
    32'hFFFF_FFFF, 32'h5599_AA66, 32'h0400_0000, 32'h0C40_0080, 32'h0002_0000,
    32'h0400_0000, 32'h0C00_0180, 32'h0000_00F0, 32'h0400_0000
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".csib"},  32'(icap_csib),  32'd1);
    check({tag, ".rdwrb"}, 32'(icap_rdwrb), 32'd1);
    check({tag, ".i"},     icap_i,          32'hFFFF_FFFF);
    check({tag, ".busy"},  32'(busy),       32'd0);
  endtask

  // Starts at a negedge in IDLE. boot is held for 'hold' edges. If abort_k
  // is non-negative, reset is raised after the checks of edge abort_k.
  task automatic run_frame(input string tag, input int hold, input int abort_k);
    logic [31:0] w;
    for (int n = 0; n < 9; n++) exp_q.push_back(frame_exp[n]);
    boot = 1'b1;
    for (int k = 0; k <= LAT + 12; k++) begin
      @(negedge clk_48mhz);
      check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
      if (k <= LAT) begin
        check($sformatf("%s.csib%0d", tag, k),  32'(icap_csib),  32'd1);
        check($sformatf("%s.rdwrb%0d", tag, k), 32'(icap_rdwrb), 32'd1);
      end else if (k == LAT + 1) begin
        check($sformatf("%s.setup_csib", tag),  32'(icap_csib),  32'd1);
        check($sformatf("%s.setup_rdwrb", tag), 32'(icap_rdwrb), 32'd0);
      end else if (k <= LAT + 10) begin
        w = exp_q.pop_front();
        check($sformatf("%s.csib%0d", tag, k),  32'(icap_csib),  32'd0);
        check($sformatf("%s.rdwrb%0d", tag, k), 32'(icap_rdwrb), 32'd0);
        check($sformatf("%s.word%0d", tag, k - LAT - 2), icap_i, w);
      end else if (k == LAT + 11) begin
        check($sformatf("%s.end_csib", tag),  32'(icap_csib),  32'd1);
        check($sformatf("%s.end_rdwrb", tag), 32'(icap_rdwrb), 32'd0);
        check($sformatf("%s.end_i", tag),     icap_i,          32'hFFFF_FFFF);
      end else begin
        check($sformatf("%s.done_csib", tag),  32'(icap_csib),  32'd1);
        check($sformatf("%s.done_rdwrb", tag), 32'(icap_rdwrb), 32'd1);
        check($sformatf("%s.done_i", tag),     icap_i,          32'hFFFF_FFFF);
      end
      if (k + 1 >= hold) boot = 1'b0;
      if (k == abort_k) begin
        reset = 1'b1;
        @(negedge clk_48mhz);
        check_idle({tag, ".abort"});
        reset = 1'b0;
        exp_q.delete();
        return;
      end
    end
    check({tag, ".q_empty"}, 32'(exp_q.size()), 32'd0);
    for (int k = LAT + 13; k < hold + 10; k++) begin
      @(negedge clk_48mhz);
      check($sformatf("%s.hold_csib%0d", tag, k),  32'(icap_csib),  32'd1);
      check($sformatf("%s.hold_rdwrb%0d", tag, k), 32'(icap_rdwrb), 32'd1);
      check($sformatf("%s.hold_busy%0d", tag, k),  32'(busy),       32'd1);
      if (k + 1 >= hold) boot = 1'b0;
    end
    boot = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    boot  = 1'b0;
    repeat (3) @(negedge clk_48mhz);
    check_idle("rst_hold");
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_48mhz);
      check_idle($sformatf("rst_idle%0d", i));
    end

    run_frame("frame1", 1, -1);

    reset = 1'b1;
    @(negedge clk_48mhz);
    check_idle("rst2");
    reset = 1'b0;
    run_frame("retrig", 50, -1);

    reset = 1'b1;
    @(negedge clk_48mhz);
    check_idle("rst3");
    reset = 1'b0;
    run_frame("abort", 1, LAT + 6);
    run_frame("rerun", 1, -1);

    reset = 1'b1;
    @(negedge clk_48mhz);
    boot = 1'b1;
    @(negedge clk_48mhz);
    check_idle("simul");
    reset = 1'b0;
    boot  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_48mhz);
      check_idle($sformatf("simul_after%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icap_warmboot.md
# icap_warmboot

Reboot sequencer for the Arty A7-35 bootloader build. On a `boot` request from `tinyfpga_bootloader` it waits out an optional hold-off, then drives the ICAPE2 write port with the IPROG command frame, so the FPGA reconfigures from the user image at `WBSTAR` in the SPI flash. It sits directly downstream of the bootloader's `boot` output in the board top level. Its ICAP outputs connect straight to an `ICAPE2` primitive (ICAP_WIDTH "X32") clocked by `clk_48mhz`.

## Interface

Parameters:
- `WBSTAR`, 32'h0040_0000: warm-boot start address written to the WBSTAR register. Bits [28:0] are the flash byte address; RS bits are zero.
- `BOOT_DELAY`, 4_800_000: hold-off in `clk_48mhz` cycles (100 ms). Used only with `WARMBOOT_DELAY_EN`.

Ports:
- `clk_48mhz`, input, 1: sole clock, 48 MHz from the MMCM.
- `reset`, input, 1: synchronous, active-high reset.
- `boot`, input, 1: reboot request from the bootloader. Level-sampled.
- `icap_csib`, output, 1: ICAPE2 CSIB. Active low.
- `icap_rdwrb`, output, 1: ICAPE2 RDWRB. 0 selects write.
- `icap_i`, output, 32: ICAPE2 I. Already bit-swapped within each byte.
- `busy`, output, 1: high from request acceptance until reset.

## Operation

- Reset is synchronous and active-high: one fixed clock, `clk_48mhz`.
- All outputs are registered. Reset values: `icap_csib`=1, `icap_rdwrb`=1, `icap_i`=32'hFFFF_FFFF, `busy`=0, state IDLE.
- States and transitions:
  - IDLE: waits for `boot`. `boot`=1 at a rising edge goes to DELAY, or to SETUP when the delay feature is compiled out. `busy` is set at that edge.
  - DELAY: a down-counter loaded with `BOOT_DELAY`-1 counts to 0, then goes to SETUP. Counter width is $clog2(BOOT_DELAY).
  - SETUP: exactly one cycle with `icap_rdwrb`=0 and `icap_csib`=1. The RDWRB change must precede CSIB assertion.
  - WRITE: 9 consecutive cycles with `icap_csib`=0, `icap_rdwrb`=0, one word per cycle, indexed by a 4-bit counter 0..8.
  - DONE: `icap_csib`=1, then `icap_rdwrb`=1 one cycle later, `icap_i`=32'hFFFF_FFFF. Terminal; only `reset` leaves it.
- Frame, logical words in order:
  - FFFFFFFF (dummy)
  - AA995566 (sync)
  - 20000000 (NOOP)
  - 30020001 (write WBSTAR)
  - `WBSTAR`
  - 20000000 (NOOP)
  - 30008001 (write CMD)
  - 0000000F (IPROG)
  - 20000000 (NOOP)
- Bit-swap rule: `icap_i[8k+j]` = word[8k+7-j], for k=0..3 and j=0..7. The swap is combinational on constants and folded into a ROM.
- `boot` is ignored in every state except IDLE. Re-assertion or glitches after acceptance have no effect.
- A `reset` asserted mid-DELAY or mid-WRITE returns to the reset values on the next edge and aborts the frame. A partial frame without IPROG does not reconfigure the device; the sequence is re-runnable after reset.
- `reset` and `boot` high at the same edge: reset wins, and the state remains IDLE.

## Timing

- Edge E0 samples `boot`=1 in IDLE. With no delay, at E1 `busy`=1 and `icap_rdwrb`=0.
- E2..E10: `icap_csib`=0, carrying words 0..8 on successive edges.
- E11: `icap_csib`=1.
- E12: `icap_rdwrb`=1.
- With delay, every step after acceptance shifts by `BOOT_DELAY` cycles.
- No backpressure: ICAPE2 accepts one word per clock at 48 MHz.

## Configuration

- `WARMBOOT_DELAY_EN` defined: the DELAY state and counter are built. They give USB time to complete the status stage of the boot request before reconfiguration drops the device.
- Not defined: no counter logic; IDLE goes directly to SETUP, and the `BOOT_DELAY` parameter is unused.

## Test plan

- Reset check: hold `reset` for 3 cycles, then release with `boot`=0 for 100 cycles. Outputs must stay `icap_csib`=1, `icap_rdwrb`=1, `icap_i`=FFFFFFFF, `busy`=0.
- Full frame, delay off, default `WBSTAR`: pulse `boot` for 1 cycle.
  - After one SETUP cycle, `icap_i` must read FFFFFFFF, 5599AA66, 04000000, 0C400080, 00020000, 04000000, 0C000180, 000000F0, 04000000 with `icap_csib`=0 for exactly 9 cycles.
  - Then `icap_csib`=1, then `icap_rdwrb`=1.
- Delay on, `BOOT_DELAY`=10: assert `boot`. `icap_rdwrb` must fall exactly 10 cycles later than in the no-delay run, and `busy`=1 throughout.
- Re-trigger: hold `boot`=1 for 50 cycles. Exactly one frame is issued and the block stays in DONE with `icap_csib`=1.
- Mid-frame reset: assert `reset` on WRITE word 4. Outputs return to reset values on the next edge. A new `boot` afterwards then produces a complete, correct 9-word frame.
- Simultaneous `reset`=1 and `boot`=1 for 1 cycle, then both 0: no frame is issued and `busy` stays 0.
